// File: rtl/wlo_sweep_pkg.sv
// Shared types and constants for the word-length sweep sequencer.
package wlo_sweep_pkg;

    localparam int unsigned SW_W  = 8;
    localparam int unsigned MSE_W = 64;

    localparam logic [SW_W-1:0] W_INIT_DEF = 8'h1E;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        SRST  = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        EVAL  = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/wlo_sweep_sequencer_if.sv
// Signal bundle between the sweep sequencer, its controller and the emulation core.
// Optional trial counter port appears when WLO_SWEEP_TRIAL_CNT_EN is defined.
interface wlo_sweep_sequencer_if
    import wlo_sweep_pkg::*;
#(
    parameter int unsigned NUM_CHAN = 3
);

    logic                           go;
    logic [MSE_W-1:0]               threshold;
    logic [MSE_W-1:0]               mse_data;
    logic                           mse_valid;
    logic [NUM_CHAN-1:0][SW_W-1:0]  sw_frac;
    logic                           start;
    logic                           soft_rstn;
    logic                           busy;
    logic                           done;
    logic                           timeout_err;
`ifdef WLO_SWEEP_TRIAL_CNT_EN
    logic [15:0]                    trial_cnt;
`endif

    // Sequencer side
    modport master (
        input  go, threshold, mse_data, mse_valid,
`ifdef WLO_SWEEP_TRIAL_CNT_EN
        output trial_cnt,
`endif
        output sw_frac, start, soft_rstn, busy, done, timeout_err
    );

    // Controller / emulation-core side
    modport slave (
        output go, threshold, mse_data, mse_valid,
`ifdef WLO_SWEEP_TRIAL_CNT_EN
        input  trial_cnt,
`endif
        input  sw_frac, start, soft_rstn, busy, done, timeout_err
    );

endinterface

// File: rtl/sweep_watchdog.sv
// Trial watchdog: reloads to TIMEOUT_CYC-1 on clear, counts down while enabled,
// and flags expiry when the count reaches zero (i.e. on the TIMEOUT_CYC-th enabled cycle).
module sweep_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned    CntW   = $clog2(TIMEOUT_CYC);
    localparam logic [CntW-1:0] Reload = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q;

    // Down-counter; holds at zero so expiry stays asserted until the next clear
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= Reload;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/wlo_sweep_sequencer.sv
// Greedy per-channel fraction-width sweep. Each trial trims one fraction bit, soft-resets
// and starts the emulation, then keeps or restores the width based on the returned MSE.
// Optional feature macro: WLO_SWEEP_TRIAL_CNT_EN (adds a saturating 16-bit trial counter).
module wlo_sweep_sequencer
    import wlo_sweep_pkg::*;
#(
    parameter int unsigned     NUM_CHAN    = 3,
    parameter logic [SW_W-1:0] W_INIT      = W_INIT_DEF,
    parameter logic [SW_W-1:0] W_MIN       = 8'h01,
    parameter int unsigned     TIMEOUT_CYC = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    wlo_sweep_sequencer_if.master bus
);

    localparam int unsigned    ChW    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam logic [ChW-1:0] LastCh = ChW'(NUM_CHAN - 1);
    // A zero width is never applied even if W_MIN is configured as zero
    localparam logic [SW_W-1:0] WFloor = (W_MIN == '0) ? SW_W'(1) : W_MIN;

    state_t                        state;
    logic [ChW-1:0]                ch;
    logic [NUM_CHAN-1:0][SW_W-1:0] sw_frac_q;
    logic [SW_W-1:0]               saved_q;
    logic [MSE_W-1:0]              thr_q;
    logic [MSE_W-1:0]              mse_q;
    logic                          timeout_err_q;
    logic                          wdog_expired;

    sweep_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == START),
        .en      (state == WAIT),
        .expired (wdog_expired)
    );

    // Sweep FSM: channel index, switch registers, saved width and captured operands
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ch            <= '0;
            sw_frac_q     <= {NUM_CHAN{W_INIT}};
            saved_q       <= W_INIT;
            thr_q         <= '0;
            mse_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.go) begin
                        thr_q         <= bus.threshold;
                        sw_frac_q     <= {NUM_CHAN{W_INIT}};
                        ch            <= '0;
                        timeout_err_q <= 1'b0;
                        state         <= APPLY;
                    end
                end
                APPLY: begin
                    if (sw_frac_q[ch] <= WFloor) begin
                        if (ch == LastCh) begin
                            state <= DONE;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end else begin
                        saved_q       <= sw_frac_q[ch];
                        sw_frac_q[ch] <= sw_frac_q[ch] - 1'b1;
                        state         <= SRST;
                    end
                end
                SRST:  state <= START;
                START: state <= WAIT;
                WAIT: begin
                    // A result on the expiry cycle still counts as a valid trial
                    if (bus.mse_valid) begin
                        mse_q <= bus.mse_data;
                        state <= EVAL;
                    end else if (wdog_expired) begin
                        sw_frac_q[ch] <= saved_q;
                        timeout_err_q <= 1'b1;
                        state         <= DONE;
                    end
                end
                EVAL: begin
                    if (mse_q <= thr_q) begin
                        state <= APPLY;
                    end else begin
                        sw_frac_q[ch] <= saved_q;
                        if (ch == LastCh) begin
                            state <= DONE;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= APPLY;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WLO_SWEEP_TRIAL_CNT_EN
    logic [15:0] trial_cnt_q;

    // Counts EVAL entries since the last accepted go; saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            trial_cnt_q <= '0;
        end else if ((state == IDLE) && bus.go) begin
            trial_cnt_q <= '0;
        end else if ((state == EVAL) && (trial_cnt_q != 16'hFFFF)) begin
            trial_cnt_q <= trial_cnt_q + 1'b1;
        end
    end

    assign bus.trial_cnt = trial_cnt_q;
`endif

    assign bus.sw_frac     = sw_frac_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.start       = (state == START);
    assign bus.soft_rstn   = (state != SRST);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_wlo_sweep_sequencer.sv
// Self-checking bench for wlo_sweep_sequencer with an emulation-core responder and a
// reference model of the greedy sweep. Honours WLO_SWEEP_TRIAL_CNT_EN when defined.
module tb_wlo_sweep_sequencer;

    localparam int unsigned NUM_CHAN = 3;
    localparam int unsigned TMO      = 16;
    localparam logic [7:0]  WI       = 8'h1E;
    localparam logic [7:0]  WM       = 8'h1C;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [63:0] threshold;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        inj_valid;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_start = 0;
    int          n_srst = 0;
    int          n_done = 0;
    bit          resp_en = 1'b1;
    int          mode = 0;
    int unsigned k [NUM_CHAN];

    always #5 clk = ~clk;

    wlo_sweep_sequencer_if #(.NUM_CHAN(NUM_CHAN)) bus ();

    assign bus.go        = go;
    assign bus.threshold = threshold;
    assign bus.mse_valid = resp_valid | inj_valid;
    assign bus.mse_data  = inj_valid ? 64'h0 : resp_data;

    wlo_sweep_sequencer #(
        .NUM_CHAN    (NUM_CHAN),
        .W_INIT      (WI),
        .W_MIN       (WM),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Emulation MSE as a function of the applied widths
    function automatic logic [63:0] mse_of(input logic [7:0] w [NUM_CHAN]);
        logic [63:0] acc = 64'd0;
        case (mode)
            0: acc = 64'd0;
            1: acc = (w[1] < 8'h1D) ? 64'd100 : 64'd5;
            default: begin
                for (int c = 0; c < NUM_CHAN; c++)
                    acc += 64'(k[c]) * 64'(32'(WI) - 32'(w[c]));
            end
        endcase
        return acc;
    endfunction

    // Reference greedy sweep: trim each channel until a trial fails or the floor is hit
    task automatic model_sweep(input logic [63:0] thr, output logic [7:0] w [NUM_CHAN],
                               output int trials);
        trials = 0;
        for (int c = 0; c < NUM_CHAN; c++) w[c] = WI;
        for (int c = 0; c < NUM_CHAN; c++) begin
            while (w[c] > WM) begin
                w[c] = w[c] - 8'd1;
                trials++;
                if (mse_of(w) > thr) begin
                    w[c] = w[c] + 8'd1;
                    break;
                end
            end
        end
    endtask

    // Emulation-core responder and pulse counters
    initial begin
        bit          pending = 1'b0;
        int          dly = 0;
        logic [7:0]  cur [NUM_CHAN];
        resp_valid = 1'b0;
        resp_data  = 64'd0;
        forever begin
            @(negedge clk);
            resp_valid = 1'b0;
            if (rst) pending = 1'b0;
            if (pending) begin
                if (dly == 0) begin
                    for (int c = 0; c < NUM_CHAN; c++) cur[c] = bus.sw_frac[c];
                    resp_data  = mse_of(cur);
                    resp_valid = 1'b1;
                    pending    = 1'b0;
                end else begin
                    dly--;
                end
            end
            if (bus.start) begin
                n_start++;
                if (resp_en) begin
                    pending = 1'b1;
                    dly     = int'($urandom_range(0, 6));
                end
            end
            if (!bus.soft_rstn) n_srst++;
            if (bus.done) n_done++;
        end
    end

    task automatic check_idle_defaults(input string tag);
        for (int c = 0; c < NUM_CHAN; c++)
            check_eq($sformatf("%s_sw%0d", tag, c), 64'(bus.sw_frac[c]), 64'(WI));
        check_eq({tag, "_start"}, 64'(bus.start), 64'd0);
        check_eq({tag, "_srstn"}, 64'(bus.soft_rstn), 64'd1);
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_done"}, 64'(bus.done), 64'd0);
        check_eq({tag, "_tmo"}, 64'(bus.timeout_err), 64'd0);
    endtask

    // One full sweep with go-latency, result and pulse-count checks
    task automatic run_sweep(input string tag, input logic [63:0] thr, input bit glitch);
        logic [7:0] exp_w [NUM_CHAN];
        int         exp_trials;
        int         s0, r0, d0;
        bit         seen;
        model_sweep(thr, exp_w, exp_trials);
        s0 = n_start; r0 = n_srst; d0 = n_done;
        threshold = thr;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_eq({tag, "_busy_n1"}, 64'(bus.busy), 64'd1);
        check_eq({tag, "_tmo_clr"}, 64'(bus.timeout_err), 64'd0);
`ifdef WLO_SWEEP_TRIAL_CNT_EN
        check_eq({tag, "_tcnt_clr"}, 64'(bus.trial_cnt), 64'd0);
`endif
        @(negedge clk);
        check_eq({tag, "_srstn_n2"}, 64'(bus.soft_rstn), 64'd0);
        @(negedge clk);
        check_eq({tag, "_start_n3"}, 64'(bus.start), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            go = glitch && ($urandom_range(0, 5) == 0);
        end
        go = 1'b0;
        check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
`ifdef WLO_SWEEP_TRIAL_CNT_EN
        check_eq({tag, "_tcnt"}, 64'(bus.trial_cnt), 64'(exp_trials));
`endif
        for (int c = 0; c < NUM_CHAN; c++)
            check_eq($sformatf("%s_sw%0d", tag, c), 64'(bus.sw_frac[c]), 64'(exp_w[c]));
        check_eq({tag, "_tmo"}, 64'(bus.timeout_err), 64'd0);
        @(negedge clk);
        #1;
        check_eq({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
        check_eq({tag, "_starts"}, 64'(n_start - s0), 64'(exp_trials));
        check_eq({tag, "_srsts"}, 64'(n_srst - r0), 64'(exp_trials));
        check_eq({tag, "_dones"}, 64'(n_done - d0), 64'd1);
    endtask

    // Starts a sweep with no responder and waits for the start pulse
    task automatic go_wait_start(input string tag);
        bit seen = 1'b0;
        threshold = 64'd0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.start) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_start_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        int cnt, s0, d0;
        rst = 1'b1; go = 1'b0; threshold = 64'd0; inj_valid = 1'b0;
        for (int c = 0; c < NUM_CHAN; c++) k[c] = 0;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_defaults("rst");

        // Always-pass model: every channel reaches the floor
        mode = 0;
        run_sweep("pass", 64'd10, 1'b0);

        // Channel 1 fails below 1D
        mode = 1;
        run_sweep("ch1fail", 64'd50, 1'b0);

        // Timeout: no result ever returned
        resp_en = 1'b0;
        s0 = n_start; d0 = n_done;
        go_wait_start("tmo");
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (bus.done) break;
        end
        check_eq("tmo_wait_cycles", 64'(cnt), 64'(TMO + 1));
        check_eq("tmo_err", 64'(bus.timeout_err), 64'd1);
        for (int c = 0; c < NUM_CHAN; c++)
            check_eq($sformatf("tmo_sw%0d", c), 64'(bus.sw_frac[c]), 64'(WI));
        @(negedge clk);
        #1;
        check_eq("tmo_starts", 64'(n_start - s0), 64'd1);
        check_eq("tmo_dones", 64'(n_done - d0), 64'd1);
        check_eq("tmo_err_sticky", 64'(bus.timeout_err), 64'd1);
        resp_en = 1'b1;

        // go pulses while busy are ignored; go clears timeout_err
        mode = 0;
        run_sweep("glitch", 64'd10, 1'b1);

        // mse_valid in IDLE is ignored
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        @(negedge clk);
        check_eq("idle_mv_busy", 64'(bus.busy), 64'd0);
        check_eq("idle_mv_start", 64'(bus.start), 64'd0);

        // Reset during WAIT
        resp_en = 1'b0;
        go_wait_start("rstwait");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_defaults("rstwait");
        d0 = n_done;
        repeat (25) @(negedge clk);
        #1;
        check_eq("rstwait_no_done", 64'(n_done - d0), 64'd0);
        resp_en = 1'b1;

        // Randomised sweeps against the reference model
        for (int it = 0; it < 12; it++) begin
            mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
            for (int c = 0; c < NUM_CHAN; c++) k[c] = $urandom_range(0, 40);
            run_sweep($sformatf("rnd%0d", it), 64'($urandom_range(0, 100)),
                      1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
